// File: rtl/rr_capture_arbiter_if.sv
// Request/grant/capture bundle shared between the requesters and the capture arbiter.
// Latency: none (wires only); the arbiter registers every output it drives.
// Backpressure: none; requesters keep req high until they see their grant.
interface rr_capture_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         out;
  logic                     out_valid;

  // Requester side: drives requests and data, observes grant and capture.
  modport master (
    output req, data_in,
    input  gnt, out, out_valid
  );

  // Arbiter side: samples requests and data, owns grant and capture register.
  modport slave (
    input  req, data_in,
    output gnt, out, out_valid
  );
endinterface

// File: rtl/rr_capture_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit capture register among NUM_REQ requesters.
// Latency: grant and captured data appear 1 cycle after req is seen in IDLE, held HOLD_CYCLES cycles.
// Backpressure: req is ignored while a grant is held; at least one idle cycle separates grants.
module rr_capture_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input logic                   clk,
  input logic                   rst,
  rr_capture_arbiter_if.slave   bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 out_valid_q, out_valid_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [7:0]           cnt_q, cnt_d;

  logic                 found;
  logic [PTR_W-1:0]     win;

  // Winner search: first set request bit at or above ptr, wrapping past NUM_REQ-1.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  // Next-state and output logic; everything holds unless a grant starts or ends.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d       = '0;
          gnt_d[win]  = 1'b1;
          out_d       = bus.data_in[int'(win)*WIDTH +: WIDTH];
          out_valid_d = 1'b1;
          cnt_d       = 8'(HOLD_CYCLES - 1);
          ptr_d       = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // Release the grant but keep the captured word visible on out.
          gnt_d       = '0;
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // State register; reset clears everything without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_capture_arbiter.sv
// Bench for rr_capture_arbiter: HOLD_CYCLES=2 instance against a cycle model, HOLD_CYCLES=1 instance against literals.
// Latency: model predicts grant one edge after req is seen idle, held for HOLD cycles.
// Backpressure: none modelled beyond the arbiter ignoring req while a grant is held.
module tb_rr_capture_arbiter;
  localparam int N      = 4;
  localparam int W      = 8;
  localparam int HOLD_A = 2;
  localparam int HOLD_B = 1;

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  rr_capture_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus_a ();
  rr_capture_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus_b ();

  rr_capture_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(HOLD_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  rr_capture_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD_CYCLES(HOLD_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Round-robin rule: first requester at or after p, wrapping.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int o = 0; o < N; o++) begin
      if (r[(p + o) % N]) return (p + o) % N;
    end
    return -1;
  endfunction

  // Model of the HOLD_CYCLES=2 instance: who owns the register, for how many more cycles, and what was captured.
  logic          m_busy  = 1'b0;
  int            m_left  = 0;
  int            m_owner = 0;
  logic [W-1:0]  m_out   = '0;
  int            m_ptr   = 0;

  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_busy  <= 1'b0;
      m_left  <= 0;
      m_owner <= 0;
      m_out   <= '0;
      m_ptr   <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_busy <= 1'b0;
    end else if (bus_a.req != '0) begin
      w        = pick(bus_a.req, m_ptr);
      m_owner <= w;
      m_out   <= bus_a.data_in[w*W +: W];
      m_busy  <= 1'b1;
      m_left  <= HOLD_A;
      m_ptr   <= (w + 1) % N;
    end
  end

  // Every falling edge: outputs of instance A must match the model.
  always @(negedge clk) begin
    check("model_gnt", 32'(bus_a.gnt), m_busy ? (32'd1 << m_owner) : 32'd0);
    check("model_out", 32'(bus_a.out), 32'(m_out));
    check("model_vld", 32'(bus_a.out_valid), 32'(m_busy));
  end

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  int           order_q[$];
  int           cyc_q[$];
  logic [N-1:0] prev_g;
  logic [N-1:0] exp_gb [6];
  logic [W-1:0] exp_ob [6];

  initial begin
    rst           = 1'b1;
    bus_a.req     = '0;
    bus_a.data_in = '0;
    bus_b.req     = '0;
    bus_b.data_in = {8'h00, 8'h00, 8'hC2, 8'hC1};
    #1;
    check("rst_gnt", 32'(bus_a.gnt), 32'd0);
    check("rst_out", 32'(bus_a.out), 32'd0);
    check("rst_vld", 32'(bus_a.out_valid), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Grant requester 0, then hit reset in the middle of its hold.
    bus_a.req     = 4'b0001;
    bus_a.data_in = {8'h44, 8'h33, 8'h22, 8'h77};
    tick();
    check("pre_rst_gnt", 32'(bus_a.gnt), 32'h1);
    check("pre_rst_out", 32'(bus_a.out), 32'h77);
    bus_a.req = 4'b1111;
    #1;
    rst = 1'b1;
    #1;
    check("midhold_rst_gnt", 32'(bus_a.gnt), 32'd0);
    check("midhold_rst_out", 32'(bus_a.out), 32'd0);
    check("midhold_rst_vld", 32'(bus_a.out_valid), 32'd0);
    tick();
    rst = 1'b0;

    // Fairness with all four requesting: 0,1,2,3,0 every third cycle.
    prev_g = '0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (bus_a.gnt != '0 && prev_g == '0) begin
        order_q.push_back(onehot_idx(bus_a.gnt));
        cyc_q.push_back(c);
      end
      prev_g = bus_a.gnt;
    end
    check("rr_count", 32'(order_q.size()), 32'd5);
    if (order_q.size() == 5) begin
      check("rr_first_after_rst", 32'(order_q[0]), 32'd0);
      check("rr_ord1", 32'(order_q[1]), 32'd1);
      check("rr_ord2", 32'(order_q[2]), 32'd2);
      check("rr_ord3", 32'(order_q[3]), 32'd3);
      check("rr_ord4", 32'(order_q[4]), 32'd0);
      for (int i = 1; i < 5; i++) check("rr_spacing", 32'(cyc_q[i] - cyc_q[i-1]), 32'd3);
    end
    bus_a.req = '0;
    tick(); tick(); tick();

    // Sparse requests from a fresh pointer: 1,3,1,3.
    #1; rst = 1'b1; tick(); rst = 1'b0;
    bus_a.req = 4'b1010;
    order_q.delete();
    prev_g = '0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus_a.gnt != '0 && prev_g == '0) order_q.push_back(onehot_idx(bus_a.gnt));
      prev_g = bus_a.gnt;
    end
    check("sparse_count", 32'(order_q.size()), 32'd4);
    if (order_q.size() == 4) begin
      check("sparse_ord0", 32'(order_q[0]), 32'd1);
      check("sparse_ord1", 32'(order_q[1]), 32'd3);
      check("sparse_ord2", 32'(order_q[2]), 32'd1);
      check("sparse_ord3", 32'(order_q[3]), 32'd3);
    end
    bus_a.req = '0;
    tick(); tick(); tick();

    // Single request from requester 2 with 8'hA5.
    bus_a.req     = 4'b0100;
    bus_a.data_in = {8'h33, 8'hA5, 8'h11, 8'h00};
    tick();
    bus_a.req = '0;
    check("single_t1_gnt", 32'(bus_a.gnt), 32'h4);
    check("single_t1_out", 32'(bus_a.out), 32'hA5);
    check("single_t1_vld", 32'(bus_a.out_valid), 32'd1);
    tick();
    check("single_t2_gnt", 32'(bus_a.gnt), 32'h4);
    check("single_t2_vld", 32'(bus_a.out_valid), 32'd1);
    tick();
    check("single_t3_gnt", 32'(bus_a.gnt), 32'h0);
    check("single_t3_vld", 32'(bus_a.out_valid), 32'd0);
    check("single_t3_out", 32'(bus_a.out), 32'hA5);

    // Hold isolation: data and req change right after the grant edge.
    bus_a.req     = 4'b0010;
    bus_a.data_in = {8'h00, 8'h00, 8'h5A, 8'h00};
    tick();
    check("iso_grant_gnt", 32'(bus_a.gnt), 32'h2);
    check("iso_grant_out", 32'(bus_a.out), 32'h5A);
    bus_a.data_in = {8'h00, 8'h00, 8'h3C, 8'h00};
    bus_a.req     = '0;
    tick();
    check("iso_hold_gnt", 32'(bus_a.gnt), 32'h2);
    check("iso_hold_out", 32'(bus_a.out), 32'h5A);
    tick();
    check("iso_end_gnt", 32'(bus_a.gnt), 32'h0);
    tick();
    check("iso_idle_out", 32'(bus_a.out), 32'h5A);

    // HOLD_CYCLES=1 instance: one-cycle pulses alternating between 0 and 1.
    exp_gb = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
    exp_ob = '{8'hC1, 8'hC1, 8'hC2, 8'hC2, 8'hC1, 8'hC1};
    bus_b.req = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("h1_gnt", 32'(bus_b.gnt), 32'(exp_gb[i]));
      check("h1_vld", 32'(bus_b.out_valid), 32'(exp_gb[i] != '0));
      check("h1_out", 32'(bus_b.out), 32'(exp_ob[i]));
    end
    bus_b.req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_capture_arbiter.md
# rr_capture_arbiter

Round-robin arbiter that shares one registered capture datapath, a bank of WIDTH D flip-flops, among NUM_REQ requesters. A granted requester owns the capture register for HOLD_CYCLES clock cycles, which forms a multicycle-path hold window, before the next arbitration. The block is a sequencing benchmark netlist for multi-source, multicycle SDC constraints such as set_multicycle_path and set_false_path on the arbiter-to-register paths. All logic runs in a single clock domain.

## Interface
- NUM_REQ, 4, number of requesters; range 2..16
- WIDTH, 8, data width per requester and width of the capture register
- HOLD_CYCLES, 2, number of cycles a grant and its captured data are held; range 1..255
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk
- req  input  NUM_REQ  request vector; bit i is requester i
- data_in  input  NUM_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  NUM_REQ  registered one-hot grant; all-zero when idle
- out  output  WIDTH  capture register contents
- out_valid  output  1  high while out holds data for the current grant

## Operation
- State is a 2-state FSM: IDLE and HOLD. The block also keeps a round-robin pointer ptr (clog2(NUM_REQ) bits) and a hold counter cnt (8 bits).
- Reset values: state=IDLE, gnt=0, out=0, out_valid=0, ptr=0, cnt=0.
- IDLE with req==0: no change.
- IDLE with req!=0: the winner is the first set bit of req, searching upward from index ptr and wrapping from NUM_REQ-1 to 0. On the next edge:
  - gnt <= onehot(winner)
  - out <= data_in slice of the winner
  - out_valid <= 1
  - cnt <= HOLD_CYCLES-1
  - ptr <= (winner+1) mod NUM_REQ
  - state <= HOLD
- HOLD with cnt!=0: cnt decrements by 1. gnt, out and out_valid are unchanged.
- HOLD with cnt==0: on the next edge, gnt <= 0, out_valid <= 0, state <= IDLE. out keeps its value.
- req is ignored in HOLD. A requester that deasserts mid-hold does not shorten the hold. New requests wait for IDLE.
- data_in is sampled only on the grant edge. Changes to data_in during HOLD never reach out.
- out is modified only by a grant capture or by reset. It is never cleared when returning to IDLE.
- Invariants:
  - gnt is zero or one-hot at all times.
  - out_valid == (gnt != 0).
  - ptr changes only on a grant edge.
- Reset asserted mid-HOLD: all outputs clear asynchronously and ptr returns to 0. The first arbitration after reset release favours requester 0.

## Timing
- Arbitration latency: with req sampled nonzero in IDLE at cycle t, gnt and out_valid are high from cycle t+1.
- gnt and out_valid stay high for exactly HOLD_CYCLES cycles, t+1 through t+HOLD_CYCLES.
- Cycle t+HOLD_CYCLES+1 is IDLE, with gnt=0. Arbitration happens in that cycle, and the next grant is visible at t+HOLD_CYCLES+2.
- Maximum grant rate is 1 per HOLD_CYCLES+1 cycles. At least one idle cycle separates consecutive grants, even to the same requester.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset assertion takes effect without a clock edge. Deassertion is expected to be synchronous to clk by the environment. The first arbitration can occur on the first edge after deassertion.

## Test plan
- Reset check: assert rst mid-HOLD with HOLD_CYCLES=2, then release. Required: gnt=0, out=0 and out_valid=0 immediately. With req=4'b1111 after release, the first gnt is 4'b0001.
- Single request: req=4'b0100 with data_in slice 2 = 8'hA5 at cycle t. Required: gnt=4'b0100, out=8'hA5, out_valid=1 for cycles t+1 and t+2. At t+3, gnt=0, out_valid=0, out=8'hA5.
- Round-robin fairness: req=4'b1111 held constant. Required: grant order 0,1,2,3,0, with grant rising edges spaced 3 cycles apart.
- Sparse wrap: req=4'b1010 held, starting from ptr=0. Required: grant order 1,3,1,3. Requesters 0 and 2 are never granted.
- Hold isolation: during HOLD, change the winner's data slice to 8'h3C and drop req. Required: out keeps the value captured at grant, and the hold runs the full HOLD_CYCLES.
- HOLD_CYCLES=1 build: req=4'b0011 continuous. Required: gnt alternates 0001, 0000, 0010, 0000, ..., with each grant pulse 1 cycle wide.
